// File: rtl/ikbd_host_sci_pkg.sv
// Shared definitions for the host-side IKBD serial link:
// frame geometry, the default bit time and the TX/RX FSM state codes.
package ikbd_host_sci_pkg;

  localparam int IKBD_SCI_CLKS_PER_BIT = 256;
  localparam int IKBD_SCI_DATA_BITS    = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_START   = 3'd1;
  localparam logic [2:0] ST_DATA    = 3'd2;
  localparam logic [2:0] ST_STOP    = 3'd3;
  localparam logic [2:0] ST_WAIT_HI = 3'd4;

  function automatic logic last_data_bit(input logic [2:0] idx);
    return idx == 3'(IKBD_SCI_DATA_BITS - 1);
  endfunction

endpackage

// File: rtl/ikbd_host_sci_fifo.sv
// Small synchronous FIFO used as rx byte storage when the FIFO build is
// selected. DEPTH must be a power of two (>= 2) so the pointers wrap freely.
// A push into a full FIFO is only taken when a pop happens in the same cycle.
module ikbd_host_sci_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             mcu_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Storage, pointers and occupancy; memory is cleared so head reads 0 after reset
  always_ff @(posedge clk or posedge mcu_rst) begin
    if (mcu_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/ikbd_host_sci.sv
// Host end of the IKBD MCU serial link: 8N1 transmitter toward the MCU SCI
// rx pin and receiver sampling the MCU SCI txd pin, fixed bit time of
// CLKS_PER_BIT clocks. Optional build macro IKBD_HOST_SCI_RX_FIFO_EN swaps the
// single rx holding register for an RX_FIFO_DEPTH-entry FIFO.
module ikbd_host_sci
  import ikbd_host_sci_pkg::*;
#(
  parameter int CLKS_PER_BIT  = IKBD_SCI_CLKS_PER_BIT,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic       CLKx2,
  input  logic       RST,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_overrun,
  output logic       rx_frame_err,
  output logic       txd,
  input  logic       rxd
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);

  logic [2:0]    tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;

  logic          rx_meta;
  logic          rxs;
  logic          rxs_prev;
  logic          rx_fall;
  logic [2:0]    rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_stop_sample;
  logic          rx_deliver;
  logic          rx_pop;

  assign tx_ready       = (tx_state == ST_IDLE);
  assign rx_fall        = rxs_prev & ~rxs;
  assign rx_stop_sample = (rx_state == ST_STOP) && (rx_cnt == CNT_LAST);
  assign rx_deliver     = rx_stop_sample & rxs;
  assign rx_pop         = rx_valid & rx_ready;

  // Transmit FSM: start bit, eight data bits LSB first, one stop bit, each CLKS_PER_BIT clocks
  always_ff @(posedge CLKx2 or posedge RST) begin
    if (RST) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      txd      <= 1'b1;
    end else begin
      case (tx_state)
        ST_IDLE: begin
          if (tx_valid) begin
            tx_state <= ST_START;
            tx_shift <= tx_data;
            tx_cnt   <= '0;
            txd      <= 1'b0;
          end
        end
        ST_START: begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_state <= ST_DATA;
            txd      <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt <= '0;
            if (last_data_bit(tx_bit)) begin
              tx_state <= ST_STOP;
              txd      <= 1'b1;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              txd      <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt   <= '0;
            tx_state <= ST_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: begin
          tx_state <= ST_IDLE;
          txd      <= 1'b1;
        end
      endcase
    end
  end

  // Two-flop synchronizer for rxd plus a delayed copy for falling-edge detection
  always_ff @(posedge CLKx2 or posedge RST) begin
    if (RST) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      rx_meta  <= rxd;
      rxs      <= rx_meta;
      rxs_prev <= rxs;
    end
  end

  // Receive FSM: mid-bit sampling referenced to the start-bit centre, glitch rejection, stop check
  always_ff @(posedge CLKx2 or posedge RST) begin
    if (RST) begin
      rx_state <= ST_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      case (rx_state)
        ST_IDLE: begin
          if (rx_fall) begin
            rx_cnt   <= '0;
            rx_state <= ST_START;
          end
        end
        ST_START: begin
          if (rx_cnt == CNT_MID) begin
            rx_cnt <= '0;
            if (rxs) begin
              rx_state <= ST_IDLE;
            end else begin
              rx_bit   <= '0;
              rx_state <= ST_DATA;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (rx_cnt == CNT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rxs, rx_shift[7:1]};
            if (last_data_bit(rx_bit)) begin
              rx_state <= ST_STOP;
            end else begin
              rx_bit <= rx_bit + 3'd1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (rx_cnt == CNT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= rxs ? ST_IDLE : ST_WAIT_HI;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        ST_WAIT_HI: begin
          if (rxs) begin
            rx_state <= ST_IDLE;
          end
        end
        default: rx_state <= ST_IDLE;
      endcase
    end
  end

  // Frame error pulse the cycle after a stop bit sampled low
  always_ff @(posedge CLKx2 or posedge RST) begin
    if (RST) begin
      rx_frame_err <= 1'b0;
    end else begin
      rx_frame_err <= rx_stop_sample & ~rxs;
    end
  end

`ifdef IKBD_HOST_SCI_RX_FIFO_EN
  logic fifo_full;
  logic fifo_empty;
  logic fifo_push;

  assign fifo_push = rx_deliver & (~fifo_full | rx_pop);
  assign rx_valid  = ~fifo_empty;

  ikbd_host_sci_fifo #(
    .DEPTH (RX_FIFO_DEPTH),
    .WIDTH (8)
  ) u_rx_fifo (
    .clk       (CLKx2),
    .mcu_rst   (RST),
    .push      (fifo_push),
    .push_data (rx_shift),
    .pop       (rx_pop),
    .head      (rx_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Overrun only when the FIFO is full and nothing leaves in the same cycle
  always_ff @(posedge CLKx2 or posedge RST) begin
    if (RST) begin
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= rx_deliver & fifo_full & ~rx_pop;
    end
  end
`else
  // The FIFO depth only matters in the FIFO build; this keeps the parameter referenced
  if (RX_FIFO_DEPTH < 1) begin : g_unused_depth
  end

  // Single holding register: a same-cycle pop frees it for the new byte
  always_ff @(posedge CLKx2 or posedge RST) begin
    if (RST) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (rx_deliver) begin
        if (!rx_valid || rx_pop) begin
          rx_data  <= rx_shift;
          rx_valid <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (rx_pop) begin
        rx_valid <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ikbd_host_sci.sv
// Self-checking bench for ikbd_host_sci with a short bit time so many frames fit.
// The reference model works at the byte/frame level: a queue of bytes the host
// should see, counts of expected overrun and frame-error pulses, and the 10-bit
// serial image of every transmitted byte.
module tb_ikbd_host_sci;

  localparam int CPB = 16;
`ifdef IKBD_HOST_SCI_RX_FIFO_EN
  localparam int STORE_DEPTH = 4;
`else
  localparam int STORE_DEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic       rx_overrun;
  logic       rx_frame_err;
  logic       txd;
  logic       rxd;
  logic       loopBack = 1'b0;
  logic       rxdBench = 1'b1;

  int checkCount = 0;
  int passCount = 0;
  int cyc = 0;
  int lastFallCyc = 0;
  int lastValidCyc = 0;
  logic prevValid = 1'b0;

  logic [7:0] expQ[$];
  int expOvr = 0;
  int expFerr = 0;
  int ovrSeen = 0;
  int ferrSeen = 0;

  assign rxd = loopBack ? txd : rxdBench;

  ikbd_host_sci #(
    .CLKS_PER_BIT  (CPB),
    .RX_FIFO_DEPTH (4)
  ) dut (
    .CLKx2        (clk),
    .RST          (rst),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err),
    .txd          (txd),
    .rxd          (rxd)
  );

  // Free-running clock and a cycle counter used for latency measurements
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case something wedges the stimulus
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Single comparison point: counts every check and reports any difference
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // A finished byte either fits in the host-side storage or is lost as an overrun
  function automatic void modelDeliver(input logic [7:0] b);
    if (expQ.size() >= STORE_DEPTH) begin
      expOvr++;
    end else begin
      expQ.push_back(b);
    end
  endfunction

  // Receive-side monitor: every host pop must match the oldest expected byte; pulses are counted
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && !prevValid) lastValidCyc = cyc;
      if (rx_overrun) ovrSeen++;
      if (rx_frame_err) ferrSeen++;
      if (rx_valid && rx_ready) begin
        if (expQ.size() > 0) begin
          checkOutput("rx_byte", {24'd0, rx_data}, {24'd0, expQ.pop_front()});
        end else begin
          checkOutput("rx_unexpected_valid", {31'd0, rx_valid}, 32'd0);
        end
      end
    end
    prevValid = rx_valid;
  end

  // Drive one serial frame onto rxd; a low stop bit can be stretched by lowTail clocks
  task automatic applyStimulus(input logic [7:0] b, input logic stopBit, input int lowTail);
    @(posedge clk);
    #1 rxdBench = 1'b0;
    lastFallCyc = cyc;
    repeat (CPB) @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      #1 rxdBench = b[k];
      repeat (CPB) @(posedge clk);
    end
    #1 rxdBench = stopBit;
    repeat (CPB + (stopBit ? 0 : lowTail)) @(posedge clk);
    #1 rxdBench = 1'b1;
    repeat (CPB) @(posedge clk);
  endtask

  // Send one byte starting at a negedge where tx_ready is high; checks every serial clock
  // against the frame image and ends on the negedge where tx_ready must return
  task automatic sendTxByte(input logic [7:0] b);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    tx_data = ~b;
    for (int i = 1; i <= 10 * CPB; i++) begin
      @(negedge clk);
      checkOutput("tx_bit", {31'd0, txd}, {31'd0, frame[(i - 1) / CPB]});
      checkOutput("tx_busy", {31'd0, tx_ready}, 32'd0);
    end
    @(negedge clk);
    checkOutput("tx_ready_after_frame", {31'd0, tx_ready}, 32'd1);
  endtask

  // Pulse counters and the expected-byte queue must agree with the model
  task automatic checkCounters(input string tag);
    checkOutput({tag, "_overruns"}, ovrSeen, expOvr);
    checkOutput({tag, "_frame_errs"}, ferrSeen, expFerr);
    checkOutput({tag, "_pending"}, expQ.size(), 32'd0);
  endtask

  // Test sequence
  initial begin
    int lat;
    logic [7:0] b;
    logic stopBit;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_txd", {31'd0, txd}, 32'd1);
    checkOutput("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    checkOutput("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    checkOutput("rst_rx_data", {24'd0, rx_data}, 32'd0);
    checkOutput("rst_rx_overrun", {31'd0, rx_overrun}, 32'd0);
    checkOutput("rst_rx_frame_err", {31'd0, rx_frame_err}, 32'd0);
    rst = 1'b0;
    repeat (4) @(posedge clk);

    $display("[TB] tx 0xA5 then random bytes back-to-back");
    @(negedge clk);
    sendTxByte(8'hA5);
    for (int n = 0; n < 4; n++) sendTxByte(8'($urandom));

    $display("[TB] rx 0x3C with latency window");
    lastValidCyc = -100000;
    modelDeliver(8'h3C);
    applyStimulus(8'h3C, 1'b1, 0);
    lat = lastValidCyc - lastFallCyc;
    checkOutput("rx_latency_in_window", {31'd0, (lat >= CPB * 19 / 2) && (lat <= CPB * 19 / 2 + 4)}, 32'd1);
    checkCounters("rx_3c");

    $display("[TB] rx 0x55 with stop bit low");
    expFerr++;
    applyStimulus(8'h55, 1'b0, 2 * CPB);
    @(negedge clk);
    checkOutput("ferr_rx_valid", {31'd0, rx_valid}, 32'd0);
    checkCounters("rx_ferr");

    $display("[TB] short low glitch then 0x12");
    @(posedge clk);
    #1 rxdBench = 1'b0;
    repeat (CPB / 4) @(posedge clk);
    #1 rxdBench = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    @(negedge clk);
    checkOutput("glitch_rx_valid", {31'd0, rx_valid}, 32'd0);
    checkCounters("glitch");
    modelDeliver(8'h12);
    applyStimulus(8'h12, 1'b1, 0);
    checkCounters("rx_12");

    $display("[TB] random rx frames");
    for (int n = 0; n < 10; n++) begin
      b = 8'($urandom);
      stopBit = ($urandom_range(0, 3) != 0);
      if (stopBit) modelDeliver(b);
      else expFerr++;
      applyStimulus(b, stopBit, stopBit ? 0 : int'($urandom_range(0, CPB)));
      repeat ($urandom_range(0, 5)) @(posedge clk);
    end
    checkCounters("rx_random");

    $display("[TB] overrun with host stalled");
    @(posedge clk);
    #1 rx_ready = 1'b0;
    for (int k = 0; k <= STORE_DEPTH; k++) begin
      b = 8'(8'h11 * (k + 1));
      modelDeliver(b);
      applyStimulus(b, 1'b1, 0);
    end
    @(negedge clk);
    checkOutput("stall_rx_valid", {31'd0, rx_valid}, 32'd1);
    checkOutput("stall_rx_data", {24'd0, rx_data}, {24'd0, expQ[0]});
    checkOutput("stall_overruns", ovrSeen, expOvr);
    @(posedge clk);
    #1 rx_ready = 1'b1;
    repeat (STORE_DEPTH + 4) @(posedge clk);
    checkCounters("stall_drain");

    $display("[TB] reset in the middle of tx 0xFF and an rx frame");
    @(negedge clk);
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    rxdBench = 1'b0;
    repeat (CPB) @(posedge clk);
    #1 rxdBench = 1'b1;
    repeat (2 * CPB + CPB / 2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_txd", {31'd0, txd}, 32'd1);
    checkOutput("midrst_tx_ready", {31'd0, tx_ready}, 32'd1);
    checkOutput("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
    checkOutput("midrst_rx_data", {24'd0, rx_data}, 32'd0);
    expQ.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    sendTxByte(8'h01);

    $display("[TB] reset during a start bit");
    tx_data  = 8'($urandom);
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    repeat (CPB / 2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("startrst_txd", {31'd0, txd}, 32'd1);
    checkOutput("startrst_tx_ready", {31'd0, tx_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (CPB) @(posedge clk);
    checkCounters("after_reset");

    $display("[TB] loopback txd to rxd");
    loopBack = 1'b1;
    @(negedge clk);
    modelDeliver(8'h00);
    sendTxByte(8'h00);
    modelDeliver(8'h7E);
    sendTxByte(8'h7E);
    modelDeliver(8'hFF);
    sendTxByte(8'hFF);
    for (int n = 0; n < 3; n++) begin
      b = 8'($urandom);
      modelDeliver(b);
      sendTxByte(b);
    end
    repeat (4) @(posedge clk);
    checkCounters("loopback");

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
